is_array_ctrl: RTL

Sequencing controller for an input-stationary systolic array of ROWS×COLS `processing_element_is` cells. For each job it:
- clears the array,
- loads the stationary activations column by column through the `cell_sc_en` chain,
- streams K weight vectors under a valid/ready handshake, stalling the array pipeline on bubbles,
- flushes the skewed pipeline and reports completion.

It sits between the job/DMA front end and the array, and drives every control strobe the PEs consume.

---
 rtl/sa_ctrl_pkg.sv | 36 +++
 rtl/valid_delay_line.sv | 37 +++
 rtl/is_array_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sa_ctrl_pkg.sv
// Shared definitions for the systolic-array sequencing controllers.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package sa_ctrl_pkg;

  // Controller phases, fixed 3-bit encoding so both array flavours agree.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_STREAM = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Each column forwards its captured value after 2 cycles, so filling
  // COLS columns takes two cycles per column.
  function automatic int load_cyc(input int cols);
    return 2 * cols;
  endfunction

  // Cycles needed for the last accepted vector to drain the skewed array.
  function automatic int flush_cyc(input int rows, input int cols, input int stage);
    return rows + cols + stage - 1;
  endfunction

  // Cycles from an accepted vector to its result leaving the bottom row.
  function automatic int out_lat(input int rows, input int stage);
    return rows + stage + 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth valid pipeline: a bit entering in_vld emerges on out_vld DEPTH cycles later.
// Latency: DEPTH cycles; advances every cycle regardless of downstream state.
// Backpressure: none; clr empties the whole line on the next edge.
module valid_delay_line #(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic in_vld,
  output logic out_vld
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  // Shift one position per cycle; a clear discards everything in flight.
  always_comb begin
    sr_d    = sr_q << 1;
    sr_d[0] = in_vld;
    if (clr) begin
      sr_d = '0;
    end
  end

  // Register the shift state; reset empties the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign out_vld = sr_q[DEPTH-1];

endmodule

// File: rtl/is_array_ctrl.sv
// Job sequencer for the input-stationary systolic array: clear, load activations, stream weights, flush.
// Latency: start -> first wei_ready 2*COLS+2 cycles; last accept -> done FLUSH_CYC+1 cycles.
// Backpressure: wei_valid low in STREAM freezes the array (pipeline_en=0); no other stalls.
module is_array_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int STAGE = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] k_len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             act_ready,
  input  logic             wei_valid,
  output logic             wei_ready,
  output logic             bubble,
  output logic             reg_clear,
  output logic             cell_sc_en,
  output logic             cell_en,
  output logic             pipeline_en,
  output logic             cscan_en,
  output logic             out_valid
);

  localparam int LOAD_CYC  = load_cyc(COLS);
  localparam int FLUSH_CYC = flush_cyc(ROWS, COLS, STAGE);
  localparam int LAT       = out_lat(ROWS, STAGE);
  localparam int PH_W      = $clog2(max2(LOAD_CYC, FLUSH_CYC) + 1);

  localparam logic [PH_W-1:0]  LOAD_LAST  = PH_W'(LOAD_CYC - 1);
  localparam logic [PH_W-1:0]  FLUSH_LAST = PH_W'(FLUSH_CYC - 1);
  localparam logic [PH_W-1:0]  PH_ONE     = PH_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;     // cycles spent in LOAD or FLUSH
  logic [CNT_W-1:0] acc_q, acc_d;         // weight vectors accepted so far
  logic [CNT_W-1:0] klen_q, klen_d;       // job length captured at start
  logic             abort_pend_q, abort_pend_d;  // current CLEAR ends the job

  logic active;     // a job is in progress and can be aborted
  logic abort_eff;  // abort that actually affects this cycle
  logic accept;     // weight vector handshake completes this cycle
  logic last_acc;   // this accept is the k_len-th one
  logic dl_clr;

  assign active    = (state_q == ST_CLEAR) || (state_q == ST_LOAD) ||
                     (state_q == ST_STREAM) || (state_q == ST_FLUSH);
  assign abort_eff = abort && active;
  assign accept    = (state_q == ST_STREAM) && wei_valid;
  // In STREAM klen_q is at least 1, so the decrement cannot wrap.
  assign last_acc  = (acc_q == (klen_q - CNT_ONE));

  // Next-state, counter and job-length update logic.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    acc_d        = acc_q;
    klen_d       = klen_q;
    abort_pend_d = abort_pend_q;

    case (state_q)
      ST_IDLE: begin
        // start is honoured here even if abort is also high.
        if (start) begin
          klen_d       = k_len;
          state_d      = ST_CLEAR;
          phase_d      = '0;
          acc_d        = '0;
          abort_pend_d = 1'b0;
        end
      end

      ST_CLEAR: begin
        phase_d = '0;
        if (abort_pend_q) begin
          state_d      = ST_IDLE;
          abort_pend_d = 1'b0;
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (phase_q == LOAD_LAST) begin
          phase_d = '0;
          // An empty job skips both streaming and draining.
          state_d = (klen_q == '0) ? ST_DONE : ST_STREAM;
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end

      ST_STREAM: begin
        if (accept) begin
          acc_d = acc_q + CNT_ONE;
          if (last_acc) begin
            state_d = ST_FLUSH;
            phase_d = '0;
          end
        end
      end

      ST_FLUSH: begin
        if (phase_q == FLUSH_LAST) begin
          phase_d = '0;
          state_d = ST_DONE;
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort always routes through one clear cycle before returning idle.
    if (abort_eff) begin
      state_d      = ST_CLEAR;
      abort_pend_d = 1'b1;
      phase_d      = '0;
      acc_d        = '0;
    end
  end

  // Controller state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      acc_q        <= '0;
      klen_q       <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      acc_q        <= acc_d;
      klen_q       <= klen_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  // Array strobes decoded from the registered state; only the STREAM
  // handshake outputs look at wei_valid directly.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    act_ready   = 1'b0;
    wei_ready   = 1'b0;
    bubble      = 1'b0;
    reg_clear   = 1'b0;
    cell_sc_en  = 1'b0;
    cell_en     = 1'b0;
    pipeline_en = 1'b0;
    cscan_en    = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        busy      = 1'b1;
        reg_clear = 1'b1;
      end
      ST_LOAD: begin
        busy       = 1'b1;
        act_ready  = 1'b1;
        cell_sc_en = 1'b1;
      end
      ST_STREAM: begin
        busy        = 1'b1;
        cell_en     = 1'b1;
        cscan_en    = 1'b1;
        wei_ready   = wei_valid;
        pipeline_en = wei_valid;
      end
      ST_FLUSH: begin
        busy        = 1'b1;
        cell_en     = 1'b1;
        pipeline_en = 1'b1;
        bubble      = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Results are tagged only for accepted vectors: flush cycles push zero
  // bubbles whose bottom-row outputs are not results of this job.
  assign dl_clr = reg_clear || abort_eff;

  valid_delay_line #(
    .DEPTH(LAT)
  ) u_out_vld_dly (
    .clk     (clk),
    .rst     (rst),
    .clr     (dl_clr),
    .in_vld  (accept),
    .out_vld (out_valid)
  );

endmodule
